// File: rtl/mul_pkg.sv
// Shared definitions for the shared shift-add multiplier controller.
package mul_pkg;

    // Default operand width; also the number of step cycles per multiply.
    localparam int N_DEFAULT = 4;

    // Controller state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Width of a counter that must hold the values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: operand registers, 2N-bit accumulator and step counter.
// load captures fresh operands and clears acc/count; step performs one add/shift step.
module mul_shift_add_dp
    import mul_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int CNT_W = cnt_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] acc,
    output logic           last_step
);

    logic [2*N-1:0] a_reg;
    logic [N-1:0]   b_reg;
    logic [2*N-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [2*N-1:0] addend;
    logic [2*N-1:0] acc_next;
    logic [N-1:0]   b_next;

    // Multiplicand is kept zero-extended so the shift never loses bits.
    assign addend   = a_reg << cnt_reg;

    // Conditional add of the shifted multiplicand and right shift of the multiplier.
    always_comb begin
        acc_next = acc_reg;
        b_next   = b_reg >> 1;
        if (b_reg[0]) begin
            acc_next = acc_reg + addend;
        end
    end

    // Datapath registers; load has priority over step.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            a_reg   <= {{N{1'b0}}, a};
            b_reg   <= b;
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (step) begin
            acc_reg <= acc_next;
            b_reg   <= b_next;
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign acc       = acc_reg;
    assign last_step = (cnt_reg == CNT_W'(N - 1));

endmodule

// File: rtl/mul_share_ctrl.sv
// Two-port round-robin front end for a single shift-add multiplier.
// Arbitrates in IDLE, runs N step cycles, then holds the tagged product until the
// consumer takes it. The port just served loses priority for the next arbitration.
module mul_share_ctrl
    import mul_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           req1_ready,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [2*N-1:0] resp_p,
    output logic           busy
);

    localparam int CNT_W = cnt_width(N);

    state_t state_reg, state_next;
    logic   prio_reg, prio_next;
    logic   id_reg, id_next;

    logic           grant0, grant1;
    logic           accept;
    logic           handshake;
    logic           dp_load, dp_step;
    logic [N-1:0]   sel_a, sel_b;
    logic [2*N-1:0] dp_acc;
    logic           dp_last;

    // Round-robin grant: a lone requester wins, a tie goes to the priority holder.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || !prio_reg);
        grant1 = req1_valid && (!req0_valid ||  prio_reg);
    end

    // Ready only in IDLE and never while reset is held, so nothing is taken during reset.
    assign req0_ready = (state_reg == IDLE) && !rst && grant0;
    assign req1_ready = (state_reg == IDLE) && !rst && grant1;

    assign accept    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign handshake = (state_reg == DONE) && resp_ready;

    // Operands of the winning port feed the datapath load.
    assign sel_a = grant1 ? req1_a : req0_a;
    assign sel_b = grant1 ? req1_b : req0_b;

    assign dp_load = accept;
    assign dp_step = (state_reg == RUN);

    mul_shift_add_dp #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (dp_load),
        .step      (dp_step),
        .a         (sel_a),
        .b         (sel_b),
        .acc       (dp_acc),
        .last_step (dp_last)
    );

    // Next-state, priority and owner-id logic.
    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        id_next    = id_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                    id_next    = grant1;
                end
            end
            RUN: begin
                if (dp_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (handshake) begin
                    state_next = IDLE;
                    prio_next  = ~id_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Controller registers; reset discards any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
            id_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
            id_reg    <= id_next;
        end
    end

    // The accumulator is frozen in DONE, so it drives the product directly.
    assign resp_valid = (state_reg == DONE);
    assign resp_p     = dp_acc;
    assign resp_id    = id_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl: drivers feed per-port operand queues, the
// monitor predicts grants, latency and products from the arbitration rules.
module tb_mul_share_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         resp_valid, resp_ready, resp_id, busy;
    logic [2*N-1:0] resp_p;

    always #5 clk = ~clk;

    mul_share_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_p     (resp_p),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;
    int unsigned edge_cnt = 0;

    // Reference model state
    logic [8:0]  sb[$];          // {id, product}
    bit          in_flight_m = 0;
    bit          prio_m = 0;
    int unsigned acc_edge_m = 0;
    bit          model_init = 0;
    bit          rst_prev = 0;

    // Stimulus queues of {a, b}
    logic [7:0] send0[$];
    logic [7:0] send1[$];
    bit took0 = 0, took1 = 0;
    int rr_mode = 0;             // 0: always ready, 1: random, 2: held low

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor / scoreboard
    always @(negedge clk) begin
        bit eg0, eg1, ev;
        logic [8:0] front;
        logic [7:0] prod;
        eg0 = 0;
        eg1 = 0;
        ev  = 0;
        if (rst_prev) begin
            sb.delete();
            in_flight_m = 0;
            prio_m      = 0;
            model_init  = 1;
            chk("rst_p", resp_p, 0);
            chk("rst_id", resp_id, 0);
        end
        if (model_init) begin
            if (!rst && !in_flight_m) begin
                eg0 = req0_valid && (!req1_valid || !prio_m);
                eg1 = req1_valid && (!req0_valid ||  prio_m);
            end
            ev = in_flight_m && (edge_cnt >= acc_edge_m + N);
            chk("req0_ready", req0_ready, eg0);
            chk("req1_ready", req1_ready, eg1);
            chk("busy", busy, in_flight_m);
            chk("resp_valid", resp_valid, ev);
            if (ev && sb.size() > 0) begin
                front = sb[0];
                chk("resp_id", resp_id, front[8]);
                chk("resp_p", resp_p, front[7:0]);
            end
            if (in_flight_m && edge_cnt > acc_edge_m + 100) begin
                total++;
                bad++;
                $display("FAIL watchdog: response not taken within 100 cycles, got none want handshake");
                in_flight_m = 0;
                sb.delete();
            end
            if (!rst) begin
                if (ev && resp_ready && sb.size() > 0) begin
                    front = sb.pop_front();
                    $display("txn done: id=%0d p=%0d edge=%0d", front[8], front[7:0], edge_cnt + 1);
                    in_flight_m = 0;
                    prio_m = ~front[8];
                end
                if (eg0 || eg1) begin
                    if (eg1) prod = 8'(int'(req1_a) * int'(req1_b));
                    else     prod = 8'(int'(req0_a) * int'(req0_b));
                    sb.push_back({eg1, prod});
                    in_flight_m = 1;
                    acc_edge_m  = edge_cnt + 1;
                end
            end
            took0 = req0_valid && req0_ready && !rst;
            took1 = req1_valid && req1_ready && !rst;
        end
        rst_prev = rst;
    end

    // Port drivers and response back-pressure
    initial begin
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        resp_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            if (took0 && send0.size() > 0) void'(send0.pop_front());
            if (took1 && send1.size() > 0) void'(send1.pop_front());
            took0 = 0;
            took1 = 0;
            req0_valid = (send0.size() > 0);
            req1_valid = (send1.size() > 0);
            if (req0_valid) {req0_a, req0_b} = send0[0];
            else            {req0_a, req0_b} = 8'($urandom);
            if (req1_valid) {req1_a, req1_b} = send1[0];
            else            {req1_a, req1_b} = 8'($urandom);
            case (rr_mode)
                0:       resp_ready = 1;
                1:       resp_ready = 1'($urandom % 2);
                default: resp_ready = 0;
            endcase
        end
    end

    task automatic wait_idle(input int max_c);
        int c = 0;
        while ((send0.size() > 0 || send1.size() > 0 || in_flight_m) && c < max_c) begin
            @(posedge clk);
            c++;
        end
        #2;
        if (c >= max_c) begin
            total++;
            bad++;
            $display("FAIL wait_idle: still busy after %0d cycles, want idle", max_c);
        end
    endtask

    initial begin
        int c;
        rst = 1;
        // Reset held with both ports requesting, then 7*9 vs 15*15 from reset
        send0.push_back({4'd7, 4'd9});
        send1.push_back({4'd15, 4'd15});
        @(posedge clk);
        @(posedge clk);
        #2 rst = 0;
        wait_idle(300);

        // Back-pressure in DONE for three cycles
        rr_mode = 2;
        send0.push_back(8'($urandom));
        c = 0;
        while (!resp_valid && c < 50) begin
            @(posedge clk);
            c++;
        end
        if (c >= 50) begin
            total++;
            bad++;
            $display("FAIL backpressure: resp_valid got 0 want 1");
        end
        repeat (3) @(posedge clk);
        #2 rr_mode = 0;
        wait_idle(300);

        // Single request 3*5
        send0.push_back({4'd3, 4'd5});
        wait_idle(300);

        // Reset during the second RUN cycle
        send0.push_back({4'd13, 4'd11});
        c = 0;
        do begin
            @(posedge clk);
            #2;
            c++;
        end while (!(in_flight_m && edge_cnt == acc_edge_m + 1) && c < 50);
        rst = 1;
        @(posedge clk);
        #2 rst = 0;
        wait_idle(300);

        // Both ports contending, port 1 with a zero multiplicand
        for (int i = 0; i < 2; i++) begin
            send0.push_back(8'($urandom));
            send1.push_back({4'd0, 4'($urandom)});
        end
        wait_idle(300);

        // Randomised traffic with random back-pressure
        rr_mode = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom % 2) send0.push_back(8'($urandom));
            if ($urandom % 2) send1.push_back(8'($urandom));
            repeat ($urandom_range(1, 12)) @(posedge clk);
            #2;
        end
        wait_idle(3000);
        rr_mode = 0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
